// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for one single-port memory with a two-cycle
// read pipeline; reports pass/fail, a saturating miss count and first-fail data.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CAPACITY   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int STAGES = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
    logic [DATA_WIDTH-1:0] exp;
  } cmp_t;

  function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4) ? LAST_ADDR : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? '1 : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? '1 : '0;
  endfunction

  logic [2:0]            state;
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  phase;
  logic                  drn;
  logic                  first_seen;
  logic [STAGES:1]       vld_pipe;
  cmp_t [STAGES:1]       cmp_pipe;

  logic       down, two_op, is_wr, op_last, at_end, rd_issue, accept;
  logic [2:0] nxt_elem;

  assign down     = (elem == 3'd3) || (elem == 3'd4);
  assign two_op   = (elem != 3'd0) && (elem != 3'd5);
  assign is_wr    = (elem == 3'd0) || (two_op && phase);
  assign op_last  = !two_op || phase;
  assign at_end   = down ? (addr == '0) : (addr == LAST_ADDR);
  assign rd_issue = (state == S_RUN) && !is_wr;
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign nxt_elem = elem + 3'd1;

  assign mem_write_read = (state == S_RUN) && is_wr;
  assign mem_address    = addr;
  assign mem_wdata      = wdata;
  assign busy = (state == S_SETUP) || (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == 16'd0);

  // wdata is loaded on entry to SETUP and held for the whole element, so the
  // memory's delayed write-data capture always sees the element background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      elem  <= '0;
      addr  <= '0;
      wdata <= '0;
      phase <= 1'b0;
      drn   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_SETUP;
            elem  <= '0;
            addr  <= start_addr(3'd0);
            wdata <= wr_bg(3'd0);
            phase <= 1'b0;
          end
        end
        S_SETUP: begin
          state <= S_RUN;
          phase <= 1'b0;
        end
        S_RUN: begin
          if (!op_last) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!at_end) begin
              addr <= down ? addr - 1'b1 : addr + 1'b1;
            end else if (elem == 3'd5) begin
              state <= S_DRAIN;
              drn   <= 1'b0;
            end else begin
              state <= S_SETUP;
              elem  <= nxt_elem;
              addr  <= start_addr(nxt_elem);
              wdata <= wr_bg(nxt_elem);
            end
          end
        end
        S_DRAIN: begin
          drn <= 1'b1;
          if (drn) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 2 lines up with mem_rdata for the read launched two cycles earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe      <= '0;
      cmp_pipe      <= '0;
      fail_count    <= '0;
      first_seen    <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (accept) begin
      vld_pipe      <= '0;
      fail_count    <= '0;
      first_seen    <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      vld_pipe[1]      <= rd_issue;
      cmp_pipe[1].addr <= addr;
      cmp_pipe[1].elem <= elem;
      cmp_pipe[1].exp  <= rd_bg(elem);
      vld_pipe[2]      <= vld_pipe[1];
      cmp_pipe[2]      <= cmp_pipe[1];
      if (vld_pipe[2] && (mem_rdata != cmp_pipe[2].exp)) begin
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        if (!first_seen) begin
          first_seen    <= 1'b1;
          fail_addr     <= cmp_pipe[2].addr;
          fail_elem     <= cmp_pipe[2].elem;
          fail_expected <= cmp_pipe[2].exp;
          fail_actual   <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural single-port memory
// (2-cycle read, delayed wdata capture) and an optional stuck-read fault.
module tb_mbist_march_ctrl;
  localparam int DW = 8, AW = 8, CAP = 255, N = CAP + 1;
  localparam int RUN_LEN = 10 * N + 8;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          mem_write_read, busy, done, pass;
  logic [AW-1:0] mem_address, fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fail_expected, fail_actual;
  logic [15:0]   fail_count;
  logic [2:0]    fail_elem;

  int checks = 0, failures = 0;

  logic          fault_en = 1'b0;
  logic [AW-1:0] wrong_addr = '0;
  logic [DW-1:0] fix_data = '0;

  logic [DW-1:0] mem [0:N-1];
  logic [DW-1:0] wdata_d = '0, rdata_q = '0;
  logic [AW-1:0] rd_addr_q = '0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_write_read(mem_write_read), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_expected(fail_expected), .fail_actual(fail_actual)
  );

  initial for (int i = 0; i < N; i++) mem[i] = 8'h5A;

  // Memory model: write uses wdata from the previous cycle; read data appears
  // two cycles after the address; optional stuck read at wrong_addr.
  always @(posedge clk) begin
    wdata_d   <= mem_wdata;
    rd_addr_q <= mem_address;
    if (mem_write_read) mem[mem_address] <= wdata_d;
    rdata_q <= (fault_en && rd_addr_q == wrong_addr) ? fix_data : mem[rd_addr_q];
  end
  assign mem_rdata = rdata_q;

  function automatic int setup_idx(input int n);
    for (int e = 0; e < 6; e++)
      if (n == ((e == 0) ? 0 : (2 * e - 1) * N + e)) return e;
    return -1;
  endfunction

  task automatic do_run(input bit hold, output int cyc);
    int e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL start_accept: busy=%0b done=%0b pass=%0b, want 1 0 0", busy, done, pass);
    end
    checks++;
    if (fail_count !== 16'd0 || fail_addr !== '0 || fail_elem !== 3'd0 ||
        fail_expected !== '0 || fail_actual !== '0) begin
      failures++;
      $display("FAIL start_clear: cnt=%0d addr=%0h elem=%0d exp=%0h act=%0h, want all 0",
               fail_count, fail_addr, fail_elem, fail_expected, fail_actual);
    end
    cyc = LIMIT;
    for (int n = 0; n < LIMIT; n++) begin
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
      e = setup_idx(n);
      if (e >= 0) begin
        ea = (e == 3 || e == 4) ? AW'(CAP) : '0;
        ew = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        checks++;
        if (mem_write_read !== 1'b0 || mem_address !== ea || mem_wdata !== ew) begin
          failures++;
          $display("FAIL setup_bus E%0d: wr=%0b addr=%0h wdata=%0h, want wr=0 addr=%0h wdata=%0h",
                   e, mem_write_read, mem_address, mem_wdata, ea, ew);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (cyc != RUN_LEN) begin
      failures++;
      $display("FAIL run_length: got %0d cycles, want %0d", cyc, RUN_LEN);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (mem_write_read !== 1'b0 || mem_address !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_bus: wr=%0b addr=%0h wdata=%0h, want 0 0 0", mem_write_read, mem_address, mem_wdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%0b done=%0b pass=%0b, want 0 0 0", busy, done, pass);
    end
    checks++;
    if (fail_count !== 16'd0 || fail_addr !== '0 || fail_elem !== 3'd0 ||
        fail_expected !== '0 || fail_actual !== '0) begin
      failures++;
      $display("FAIL reset_diag: cnt=%0d addr=%0h elem=%0d exp=%0h act=%0h, want all 0",
               fail_count, fail_addr, fail_elem, fail_expected, fail_actual);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_fault_free(input bit hold, input string tag);
    int c;
    fault_en = 1'b0;
    do_run(hold, c);
    checks++;
    if (pass !== 1'b1 || fail_count !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: pass=%0b cnt=%0d busy=%0b, want 1 0 0", tag, pass, fail_count, busy);
    end
  endtask

  task automatic test_stuck_a5();
    int c;
    fault_en = 1'b1; wrong_addr = 8'd5; fix_data = 8'hA5;
    do_run(1'b0, c);
    checks++;
    if (fail_count !== 16'd5 || pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck_a5_count: cnt=%0d pass=%0b, want 5 0", fail_count, pass);
    end
    checks++;
    if (fail_addr !== 8'd5 || fail_elem !== 3'd1 || fail_expected !== 8'h00 || fail_actual !== 8'hA5) begin
      failures++;
      $display("FAIL stuck_a5_diag: addr=%0h elem=%0d exp=%0h act=%0h, want 5 1 00 a5",
               fail_addr, fail_elem, fail_expected, fail_actual);
    end
  endtask

  task automatic test_stuck_00();
    int c;
    fault_en = 1'b1; wrong_addr = 8'd5; fix_data = 8'h00;
    do_run(1'b0, c);
    checks++;
    if (fail_count !== 16'd2 || pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck_00_count: cnt=%0d pass=%0b, want 2 0", fail_count, pass);
    end
    checks++;
    if (fail_addr !== 8'd5 || fail_elem !== 3'd2 || fail_expected !== 8'hFF || fail_actual !== 8'h00) begin
      failures++;
      $display("FAIL stuck_00_diag: addr=%0h elem=%0d exp=%0h act=%0h, want 5 2 ff 00",
               fail_addr, fail_elem, fail_expected, fail_actual);
    end
  endtask

  task automatic test_abort_reset();
    fault_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5 * N + 3 + 40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: busy=%0b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || mem_write_read !== 1'b0 ||
        mem_address !== '0 || mem_wdata !== '0 || fail_count !== 16'd0) begin
      failures++;
      $display("FAIL abort_reset: busy=%0b done=%0b pass=%0b wr=%0b addr=%0h wdata=%0h cnt=%0d, want all 0",
               busy, done, pass, mem_write_read, mem_address, mem_wdata, fail_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%0b done=%0b, want 0 0", busy, done);
    end
    test_fault_free(1'b0, "abort_rerun");
  endtask

  initial begin
    test_reset();
    test_fault_free(1'b0, "fault_free");
    test_stuck_a5();
    test_stuck_00();
    test_fault_free(1'b1, "start_held");
    test_abort_reset();
    test_fault_free(1'b0, "back_to_back");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

Memory built-in self-test controller that runs a March C- algorithm against one single-port memory instance (`fault_mem` or the fault-free equivalent).
- Drives the memory's `write_read`, `address` and `wdata` directly.
- Tracks the memory's two-cycle read pipeline and compares every read against the expected background.
- Reports pass/fail, first-failure diagnostics and a failure count to the BIST top level.
- Sits between the chip-level test access logic and the memory under test.

## Interface
Parameters:
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 8, memory address width
- CAPACITY, 255, highest valid address; N = CAPACITY+1 words tested

Ports:
- clk  in  1  rising-edge clock shared with the memory
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- mem_write_read  out  1  1 = write, 0 = read
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data (2-cycle latency)
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- pass  out  1  valid when done=1; 1 = zero miscompares
- fail_count  out  16  number of miscompares, saturates at 16'hFFFF
- fail_addr  out  ADDR_WIDTH  address of first miscompare
- fail_elem  out  3  March element index (0-5) of first miscompare
- fail_expected  out  DATA_WIDTH  expected data of first miscompare
- fail_actual  out  DATA_WIDTH  read data of first miscompare

## Operation
- March C- element list (0 = all-zeros word, 1 = all-ones word):
  - E0 ⇑ w0
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇑ r0
- States: IDLE, SETUP, RUN, DRAIN, DONE.
  - IDLE/DONE → SETUP on start=1; this clears fail_count, the first-fail flag and all fail_* registers, and sets element index to 0.
  - SETUP: one cycle.
    - Drives mem_write_read=0, mem_address=element start address (0 for ⇑, CAPACITY for ⇓), and mem_wdata=element write background.
    - The read issued in SETUP is not compared.
    - SETUP → RUN.
  - RUN: one memory operation per cycle.
    - Two-op elements issue read then write on the same address in consecutive cycles, then step the address.
    - The address increments for ⇑ and decrements for ⇓.
    - mem_wdata is held constant for the whole element. This satisfies the memory's one-cycle internal wdata delay.
    - After the last op of E0-E4: element index +1, → SETUP.
    - After the last op of E5 → DRAIN.
  - DRAIN: two cycles, mem_write_read=0 with the last address held, no compare launched. → DONE.
  - DONE: done=1, busy=0. pass = (fail_count==0).
- Compare pipeline:
  - Each RUN read pushes {valid, address, element, expected} into a 2-stage shift register.
  - At stage 2, mem_rdata is compared against expected and the result registered.
  - On mismatch, fail_count increments (saturating).
  - If no failure has been recorded yet, fail_addr, fail_elem, fail_expected and fail_actual are captured; later failures do not overwrite them.
- start while busy=1 is ignored.
- Reset mid-test aborts immediately to IDLE. Memory contents are left as-is.
- Reset values:
  - mem_write_read=0, mem_address=0, mem_wdata=0
  - busy=0, done=0, pass=0
  - fail_count=0, all fail_* = 0

## Timing
- Cycle k is the rising edge where start=1 is sampled. busy=1 from k+1.
- Total cycles from the first SETUP to the first DONE cycle: 10N op cycles + 6 SETUP + 2 DRAIN = 10N+8. done rises at edge k+10N+8.
- Read issued in cycle t: mem_rdata is valid in cycle t+2, and the compare result is registered at the edge closing cycle t+2.
- The last E5 read completes compare at the edge entering DONE, so fail_* and pass are stable when done=1.
- Write in cycle t: mem_wdata was already equal to the write data in cycle t-1 (guaranteed by SETUP).
- Address wrap: none. ⇑ ends at CAPACITY and ⇓ ends at 0. The address counter never over- or underflows.

## Test plan
- Fault-free memory, N=256, start pulse:
  - done rises exactly 2568 cycles after start is sampled.
  - pass=1, fail_count=0.
- fault_mem with WRONG_ADDR=5, FIX_DATA=8'hA5:
  - fail_count=5.
  - fail_addr=5, fail_elem=1, fail_expected=8'h00, fail_actual=8'hA5.
  - pass=0.
- fault_mem with WRONG_ADDR=5, FIX_DATA=8'h00:
  - fail_count=2, with misses only on the r1 reads of E2 and E4.
  - fail_elem=2, fail_expected=8'hFF, fail_actual=8'h00.
- rst_n low for 1 cycle during E3:
  - All outputs return to reset values immediately.
  - A new start then runs a full test: pass=1 on the fault-free memory, length again 10N+8.
- start held high during a run:
  - No restart; done timing is unchanged.
  - start while in DONE clears pass/done/fail_* and reruns.
- Bus protocol check in every SETUP cycle:
  - mem_write_read=0.
  - mem_wdata equals the next element's background (00, FF, 00, FF, 00, 00 for E0-E5).
  - mem_address is 0 for E0-E2 and E5, CAPACITY for E3-E4.
